rx_frame_writer: RTL and testbench

Write-side controller for the RMII receive buffering path. Takes the byte stream produced by the MII/RMII receive FSM, writes each byte into the data FIFO, counts bytes per frame, and at end-of-frame pushes a length word into the count FIFO. The length word is encoded as bytes−1, so the drain-side controller can count from 0 to the length word inclusive and read exactly one frame.

---
 rtl/rx_frame_writer.sv | 74 +++++++
 tb/tb_rx_frame_writer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rx_frame_writer.sv
// rx_frame_writer: writes received bytes to the data FIFO and pushes a per-frame length word (bytes-1).
// Optional frame/drop statistics counters are enabled by defining RX_FRAME_STATS_EN.
module rx_frame_writer #(
  parameter int MAX_LEN = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_vld,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eof,
  input  logic        wr_full,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic [10:0] cnt,
  output logic        cnt_vld,
  input  logic        cnt_rdy,
  output logic        busy
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0] frames,
  output logic [15:0] drops
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH, S_PUSH} state_t;
  state_t      state;
  logic [11:0] len;
  logic        accept;
  logic [11:0] len_nx;
  assign accept = rx_vld && !wr_full && (state == S_IDLE || state == S_FRAME) && len < 12'(MAX_LEN);
  assign len_nx = accept ? len + 12'd1 : len;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      len     <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      cnt     <= '0;
      cnt_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) wr_data <= rx_byte;
      case (state)
        S_IDLE, S_FRAME: begin
          len   <= len_nx;
          state <= len_nx == '0 ? S_IDLE : rx_eof ? S_FLUSH : S_FRAME;
          busy  <= len_nx != '0;
        end
        S_FLUSH: begin
          cnt     <= 11'(len - 12'd1);
          cnt_vld <= 1'b1;
          state   <= S_PUSH;
        end
        default: if (cnt_rdy) begin
          cnt_vld <= 1'b0;
          len     <= '0;
          state   <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
`ifdef RX_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames <= '0;
      drops  <= '0;
    end else begin
      if (state == S_PUSH && cnt_rdy) frames <= frames + 16'd1;
      if (rx_vld && !accept) drops <= drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rx_frame_writer.sv
// tb_rx_frame_writer: directed self-checking bench for rx_frame_writer.
module tb_rx_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_vld = 1'b0, rx_eof = 1'b0, wr_full = 1'b0, cnt_rdy = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        wr_en, cnt_vld, busy;
  logic [7:0]  wr_data;
  logic [10:0] cnt;
  logic [15:0] frames, drops;
  int          checks = 0, errors = 0;
  logic [7:0]  wq[$];
  logic [10:0] cq[$];

  rx_frame_writer #(.MAX_LEN(2048)) dut (
    .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_byte(rx_byte), .rx_eof(rx_eof),
    .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data), .cnt(cnt), .cnt_vld(cnt_vld),
    .cnt_rdy(cnt_rdy), .busy(busy)
`ifdef RX_FRAME_STATS_EN
    , .frames(frames), .drops(drops)
`endif
  );
`ifndef RX_FRAME_STATS_EN
  assign frames = '0;
  assign drops  = '0;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) wq.push_back(wr_data);
    if (rst_n === 1'b1 && cnt_vld === 1'b1 && cnt_rdy) cq.push_back(cnt);
  end

  task automatic cyc(input logic v, input logic [7:0] b, input logic e);
    rx_vld = v; rx_byte = b; rx_eof = e;
    @(posedge clk); #1;
    rx_vld = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", wr_data); end
    checks++; if (cnt !== 11'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    checks++; if (cnt_vld !== 1'b0) begin errors++; $display("FAIL reset_cnt_vld got %0b exp 0", cnt_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (frames !== 16'd0 || drops !== 16'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", frames, drops); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_frame64;
    int bad = 0;
    wq.delete(); cq.delete(); cnt_rdy = 1'b1;
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), i == 63);
    checks++; if (wr_en !== 1'b1 || wr_data !== 8'h3F || cnt_vld !== 1'b0) begin errors++; $display("FAIL f64_flush got en=%0b data=%0h vld=%0b exp 1/3f/0", wr_en, wr_data, cnt_vld); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (cnt_vld !== 1'b1 || cnt !== 11'd63) begin errors++; $display("FAIL f64_cnt got vld=%0b cnt=%0d exp 1/63", cnt_vld, cnt); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (cnt_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL f64_done got vld=%0b busy=%0b exp 0/0", cnt_vld, busy); end
    if (wq.size() != 64) bad++;
    else for (int i = 0; i < 64; i++) if (wq[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL f64_data got %0d bad/%0d writes exp 0/64", bad, wq.size()); end
    checks++; if (cq.size() != 1 || cq[0] !== 11'd63) begin errors++; $display("FAIL f64_push got %0d pushes exp 1 of 63", cq.size()); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (frames !== 16'd1) begin errors++; $display("FAIL f64_frames got %0d exp 1", frames); end
`endif
  endtask

  task automatic test_single;
    wq.delete(); cq.delete(); cnt_rdy = 1'b1;
    cyc(1'b1, 8'hA5, 1'b1);
    checks++; if (wr_en !== 1'b1 || wr_data !== 8'hA5) begin errors++; $display("FAIL single_wr got en=%0b data=%0h exp 1/a5", wr_en, wr_data); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (cnt_vld !== 1'b1 || cnt !== 11'd0) begin errors++; $display("FAIL single_cnt got vld=%0b cnt=%0d exp 1/0", cnt_vld, cnt); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (wq.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL single_done got writes=%0d busy=%0b exp 1/0", wq.size(), busy); end
  endtask

  task automatic test_truncate;
    logic [15:0] d0 = drops;
    wq.delete(); cq.delete(); cnt_rdy = 1'b1;
    for (int i = 0; i < 2100; i++) cyc(1'b1, 8'(i), i == 2099);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    checks++; if (wq.size() != 2048 || wq[2047] !== 8'hFF) begin errors++; $display("FAIL trunc_writes got %0d exp 2048", wq.size()); end
    checks++; if (cq.size() != 1 || cq[0] !== 11'd2047) begin errors++; $display("FAIL trunc_cnt got %0d pushes exp 1 of 2047", cq.size()); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (drops - d0 !== 16'd52) begin errors++; $display("FAIL trunc_drops got %0d exp 52", drops - d0); end
`endif
  endtask

  task automatic test_backpressure;
    logic [15:0] d0 = drops;
    int bad = 0;
    wq.delete(); cq.delete(); cnt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h40 + 8'(i), i == 4);
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (cnt_vld !== 1'b1 || cnt !== 11'd4) begin errors++; $display("FAIL bp_first got vld=%0b cnt=%0d exp 1/4", cnt_vld, cnt); end
    for (int k = 0; k < 10; k++) begin
      cyc(k < 3, 8'hE0 + 8'(k), 1'b0);
      if (cnt_vld !== 1'b1 || cnt !== 11'd4 || wr_en !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
    checks++; if (wq.size() != 5 || cq.size() != 0) begin errors++; $display("FAIL bp_nowrite got writes=%0d pushes=%0d exp 5/0", wq.size(), cq.size()); end
    cnt_rdy = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (cnt_vld !== 1'b0 || busy !== 1'b0 || cq.size() != 1 || cq[0] !== 11'd4) begin errors++; $display("FAIL bp_push got vld=%0b busy=%0b pushes=%0d exp 0/0/1", cnt_vld, busy, cq.size()); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (drops - d0 !== 16'd3) begin errors++; $display("FAIL bp_drops got %0d exp 3", drops - d0); end
`endif
  endtask

  task automatic test_full;
    logic [15:0] d0 = drops;
    logic [7:0] exp_d[7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h17, 8'h18, 8'h19};
    int bad = 0;
    wq.delete(); cq.delete(); cnt_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_full = (i >= 4 && i <= 6);
      cyc(1'b1, 8'h10 + 8'(i), i == 9);
    end
    wr_full = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    if (wq.size() != 7) bad++;
    else for (int i = 0; i < 7; i++) if (wq[i] !== exp_d[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_data got %0d bad/%0d writes exp 0/7", bad, wq.size()); end
    checks++; if (cq.size() != 1 || cq[0] !== 11'd6) begin errors++; $display("FAIL full_cnt got %0d pushes exp 1 of 6", cq.size()); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (drops - d0 !== 16'd3) begin errors++; $display("FAIL full_drops got %0d exp 3", drops - d0); end
`endif
    wq.delete(); cq.delete();
    cyc(1'b0, 8'h00, 1'b1);
    wr_full = 1'b1;
    cyc(1'b1, 8'h55, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %0b exp 0", busy); end
    cyc(1'b1, 8'h56, 1'b1);
    wr_full = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    checks++; if (wq.size() != 0 || cq.size() != 0 || cnt_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_nopush got writes=%0d pushes=%0d exp 0/0", wq.size(), cq.size()); end
  endtask

  task automatic test_reset_mid;
    cnt_rdy = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    checks++; if (wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got en=%0b busy=%0b exp 1/1", wr_en, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_data !== 8'h00 || busy !== 1'b0 || cnt_vld !== 1'b0 || cnt !== 11'd0) begin errors++; $display("FAIL mid_async got en=%0b data=%0h busy=%0b vld=%0b cnt=%0d exp all 0", wr_en, wr_data, busy, cnt_vld, cnt); end
`ifdef RX_FRAME_STATS_EN
    checks++; if (frames !== 16'd0 || drops !== 16'd0) begin errors++; $display("FAIL mid_stats got %0d/%0d exp 0/0", frames, drops); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    wq.delete(); cq.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hC0 + 8'(i), i == 3);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    checks++; if (wq.size() != 4 || cq.size() != 1 || cq[0] !== 11'd3) begin errors++; $display("FAIL mid_next got writes=%0d pushes=%0d exp 4/1 of 3", wq.size(), cq.size()); end
  endtask

  initial begin
    test_reset;
    test_frame64;
    test_single;
    test_truncate;
    test_backpressure;
    test_full;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
